// File: rtl/gpc_alu_pkg.sv
// Shared GPC ALU definitions: datapath width, add/sub op encoding, result flags.
package gpc_alu_pkg;

  localparam int XLEN = 32;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef struct packed {
    logic ovf;
    logic zero;
    logic cout;
  } alu_flags_t;

endpackage

// File: rtl/pipe_adder_stage.sv
// One elastic slice of pipe_adder: sums chunk IDX of the travelling operands into the beat.
// Latency 1 cycle; loads whenever empty or the downstream slot takes this beat.
// Backpressure: holds its beat while dn_rdy=0 and passes the stall upstream through up_rdy.
module pipe_adder_stage
  import gpc_alu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CW    = 8,
  parameter int IDX   = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [WIDTH-1:0] up_res,
  input  logic             up_c,
  input  logic             up_op,
  input  logic             dn_rdy,
  output logic             vld,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             op,
  output logic             ovf,
  output logic             zero
);

  logic [CW:0]      csum;
  logic [WIDTH-1:0] nres;

  assign up_rdy = !vld || dn_rdy;

  always_comb begin
    csum = {1'b0, up_a[IDX*CW +: CW]} + {1'b0, up_b[IDX*CW +: CW]} + {{CW{1'b0}}, up_c};
    nres = up_res;
    nres[IDX*CW +: CW] = csum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      a   <= '0;
      b   <= '0;
      res <= '0;
      c   <= 1'b0;
      op  <= 1'b0;
    end else if (up_rdy) begin
      vld <= up_vld;
      if (up_vld) begin
        a   <= up_a;
        b   <= up_b;
        res <= nres;
        c   <= csum[CW];
        op  <= up_op;
      end
    end
  end

  // Flags only exist in the final slice, where the whole result is known.
  if (LAST) begin : g_flags
`ifdef PIPE_ADDER_FLAGS_EN
    always_ff @(posedge clk) begin
      if (rst) begin
        ovf  <= 1'b0;
        zero <= 1'b0;
      end else if (up_rdy && up_vld) begin
        ovf  <= (up_a[WIDTH-1] == up_b[WIDTH-1]) && (nres[WIDTH-1] != up_a[WIDTH-1]);
        zero <= (nres == '0);
      end
    end
`else
    assign ovf  = 1'b0;
    assign zero = 1'b0;
`endif
  end else begin : g_noflags
    assign ovf  = 1'b0;
    assign zero = 1'b0;
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined chunked adder/subtractor; ovf/zero flags built only with PIPE_ADDER_FLAGS_EN.
// Latency STAGES cycles, 1 beat/cycle; in_ready is combinational from out_ready down the valid chain.
// Backpressure: with out_ready=0 the pipe fills, in_ready drops when full, held results stay stable.
module pipe_adder
  import gpc_alu_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  logic [STAGES-1:0] st_vld;
  logic [STAGES-1:0] st_rdy;
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_op;
  logic [WIDTH-1:0]  st_a   [STAGES];
  logic [WIDTH-1:0]  st_b   [STAGES];
  logic [WIDTH-1:0]  st_res [STAGES];
  logic              st_ovf [STAGES];
  logic              st_zero[STAGES];
  alu_flags_t        flg;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             u_vld;
    logic             u_c;
    logic             u_op;
    logic             d_rdy;
    logic [WIDTH-1:0] u_a;
    logic [WIDTH-1:0] u_b;
    logic [WIDTH-1:0] u_res;

    if (k == 0) begin : g_head
      // Subtraction as A + ~B + ~borrow; the op bit rides along to fix up cout.
      assign u_vld = in_valid;
      assign u_a   = in1;
      assign u_b   = (sub == ALU_SUB) ? ~in2 : in2;
      assign u_c   = (sub == ALU_SUB) ? ~cin : cin;
      assign u_op  = sub;
      assign u_res = '0;
    end else begin : g_body
      assign u_vld = st_vld[k-1];
      assign u_a   = st_a[k-1];
      assign u_b   = st_b[k-1];
      assign u_c   = st_c[k-1];
      assign u_op  = st_op[k-1];
      assign u_res = st_res[k-1];
    end

    if (k == STAGES - 1) begin : g_tail
      assign d_rdy = out_ready;
    end else begin : g_mid
      assign d_rdy = st_rdy[k+1];
    end

    pipe_adder_stage #(
      .WIDTH(WIDTH),
      .CW   (CW),
      .IDX  (k),
      .LAST (k == STAGES - 1)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .up_vld(u_vld),
      .up_rdy(st_rdy[k]),
      .up_a  (u_a),
      .up_b  (u_b),
      .up_res(u_res),
      .up_c  (u_c),
      .up_op (u_op),
      .dn_rdy(d_rdy),
      .vld   (st_vld[k]),
      .a     (st_a[k]),
      .b     (st_b[k]),
      .res   (st_res[k]),
      .c     (st_c[k]),
      .op    (st_op[k]),
      .ovf   (st_ovf[k]),
      .zero  (st_zero[k])
    );
  end

  assign in_ready  = !rst && st_rdy[0];
  assign out_valid = st_vld[STAGES-1];
  assign out       = st_res[STAGES-1];

  always_comb begin
    flg.cout = (st_op[STAGES-1] == ALU_SUB) ? ~st_c[STAGES-1] : st_c[STAGES-1];
    flg.ovf  = st_ovf[STAGES-1];
    flg.zero = st_zero[STAGES-1];
  end

  assign cout = flg.cout;
  assign ovf  = flg.ovf;
  assign zero = flg.zero;

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined ripple-by-chunk adder/subtractor with valid/ready handshake on both sides.
- Successor to the fixed 16-bit cascaded adders: width, pipeline depth and add/sub mode are all selectable.
- Each pipeline stage resolves one WIDTH/STAGES-bit slice, so the carry chain per cycle is short.
- Sits in the GPC ALU datapath and in multi-cycle address/accumulate paths.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0: A+B+cin; 1: A-B-cin.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- out  output  WIDTH  sum/difference.
- cout  output  1  carry-out (add) / borrow-out (sub; 1 = borrow occurred).
- ovf  output  1  signed overflow (FLAGS feature).
- zero  output  1  out == 0 (FLAGS feature).

Behaviour:
- Transfer occurs on in_valid&&in_ready (input) and on out_valid&&out_ready (output).
- Stage 0 latches A and B' = sub ? ~in2 : in2, plus carry c0 = sub ? ~cin : cin.
- Stage k (0..STAGES-1) computes result bits [k*CW +: CW] = A_chunk + B'_chunk + c_k.
  - It forwards c_{k+1} and the not-yet-summed operand chunks; finished result chunks travel with the beat.
- cout = sub ? ~c_STAGES : c_STAGES.
- ovf = (A[MSB] == B'[MSB]) && (out[MSB] != A[MSB]).
- Latency: STAGES cycles from input transfer to out_valid, with no stalls. Throughput: 1 beat/cycle.
- Each stage holds a valid bit v_k. Stage k loads when stage k+1 is empty or advancing (skid-free elastic pipeline).
  - Last stage advances on out_ready.
  - in_ready = !v_0 || advance_0; it is combinational from out_ready through the valid chain.
- Backpressure with out_ready=0:
  - Pipeline fills; in_ready drops once all STAGES slots hold data.
  - No beat is lost or duplicated.
  - Outputs stay stable while out_valid && !out_ready.
- Simultaneous input and output transfer when full: both occur in the same cycle and occupancy stays STAGES.
- Order: results emerge strictly in input order.
- Wrap-around: arithmetic is modulo 2^WIDTH; carry is reported only through cout.
- Reset (including mid-operation): all v_k cleared, in-flight beats discarded.
  - Reset values: out_valid=0, out=0, cout=0, ovf=0, zero=0.
  - in_ready=1 in the cycle after reset deasserts. While rst=1, in_ready=0.
- STAGES=1: single registered add, latency 1.

Optional Feature:
- Macro: PIPE_ADDER_FLAGS_EN.
- Defined: ovf and zero are computed as above and carried with each beat. zero is derived from the full result in the final stage.
- Undefined: ovf and zero are tied 0; their registers and logic are not instantiated. out and cout are unaffected.

Decomposition:
- Shared package gpc_alu_pkg holds:
  - constant XLEN = 32;
  - op encoding localparams ALU_ADD = 1'b0, ALU_SUB = 1'b1;
  - a packed flags typedef {ovf, zero, cout}, reused by the ALU.
- One sub-module, pipe_adder_stage, instantiated STAGES times in a generate loop.
  - It holds the stage register set: valid, partial result, carry, remaining operands.
  - It contains the CW-bit chunk adder and the per-stage load/advance logic.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1. A=0xFFFF_FFFF, B=1, cin=0, sub=0 -> after 4 cycles out=0, cout=1, zero=1, ovf=0.
- sub=1, A=5, B=7, cin=0 -> out=0xFFFF_FFFE, cout=1 (borrow), ovf=0. Then A=0x8000_0000, B=1 -> out=0x7FFF_FFFF, ovf=1.
- Stream 100 random beats with out_ready toggling randomly -> every result matches the reference model, in order, with none lost or duplicated. Hold out_ready=0 for 10 cycles -> in_ready=0 after 4 accepted beats and out stays stable.
- Full pipeline with in_valid=1 and out_ready=1 for 8 cycles -> exactly one transfer in and one out per cycle, in_ready stays 1.
- Assert rst for 1 cycle with 3 beats in flight -> no out_valid afterwards until new input. in_ready=0 during rst and 1 the following cycle; out=0, cout=0.
- STAGES=1, WIDTH=8: A=0x7F, B=0x01 -> next cycle out=0x80, ovf=1 (with PIPE_ADDER_FLAGS_EN). Rebuild without the macro -> ovf=0, out unchanged.
